if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 16-bit pipelined core.
- Owns the PC and drives a variable-latency instruction-memory request/valid interface.
- Consumes the hazard unit's stall, control_stall and if_id_flush, plus the decode-stage branch target.
- Holds a one-entry fetch buffer so a fetch returning during a stall is not lost. Detects HLT and stops fetching.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, instruction word written into IF/ID on flush or reset.
- HLT_OPCODE, 4'hF, opcode (instr[15:12]) that halts fetch.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  load-to-use stall; hold PC and IF/ID.
- control_stall  in  1  branch-operand stall; hold PC and IF/ID.
- if_id_flush  in  1  taken branch resolved in decode; redirect fetch.
- br_target  in  16  redirect address, valid when if_id_flush=1.
- imem_req  out  1  fetch request for address imem_addr.
- imem_addr  out  16  current PC.
- imem_rdata  in  16  instruction word, valid when imem_valid=1.
- imem_valid  in  1  memory returns imem_rdata for the current request (same cycle allowed).
- if_id_instr  out  16  IF/ID instruction.
- if_id_pc_plus2  out  16  IF/ID PC+2 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  HLT fetched; fetch stopped.

Behaviour:
- hold = stall | control_stall. Hold has priority over if_id_flush; flush is ignored while hold=1 because the branch is unresolved.
- States:
  - FETCH: imem_req=1, waiting for imem_valid.
  - BUF: word buffered, imem_req=0.
  - HALT: imem_req=0.
- Reset is asynchronous and active-low. On reset:
  - pc=RESET_PC; state=FETCH.
  - if_id_instr=NOP_INSTR; if_id_pc_plus2=0; if_id_valid=0.
  - halted=0; buffer empty.
  - imem_req=0 while rst=0, 1 from the first cycle after release.
  - Reset mid-fetch abandons the request; any later imem_valid for it is ignored, since imem_req was low.
- imem_addr = pc at all times. pc+2 wraps modulo 2^16 (16'hFFFE -> 16'h0000).
- FETCH with hold=0 and if_id_flush=1: IF/ID <= {NOP_INSTR, 0, valid=0}; pc <= br_target; any imem_valid this cycle is discarded; stay FETCH.
- FETCH with hold=0, no flush, imem_valid=1:
  - IF/ID <= {imem_rdata, pc+2, 1}.
  - If imem_rdata[15:12]==HLT_OPCODE: pc unchanged, state=HALT, halted=1.
  - Otherwise pc <= pc+2.
  - Throughput is one instruction per cycle with a zero-wait memory.
- FETCH with hold=0, imem_valid=0: IF/ID <= bubble {NOP_INSTR, pc+2, 0}; pc unchanged.
- FETCH with hold=1: IF/ID and pc hold. If imem_valid=1, capture imem_rdata into the buffer and go to BUF.
- BUF with hold=1: everything holds.
- BUF with hold=0, flush=1: drop the buffer; IF/ID <= bubble; pc <= br_target; go to FETCH.
- BUF with hold=0, no flush: IF/ID <= {buffer, pc+2, 1}; pc <= pc+2, or enter HALT if the buffer holds HLT; go to FETCH.
- HALT:
  - hold=1: everything holds.
  - hold=0, no flush: IF/ID <= bubble each cycle.
  - hold=0, flush=1: the HLT was on the wrong path. halted <= 0; pc <= br_target; IF/ID <= bubble; go to FETCH.
  - Otherwise HALT is left only by reset.
- halted is registered: it is high exactly while state=HALT.

Test Plan:
1. Reset release, zero-wait memory returning 16'h1123, 16'h2234, ... at PC 0, 2, ... -> IF/ID shows instr 16'h1123/pc_plus2 16'h0002, then 16'h2234/16'h0004 on consecutive cycles, valid=1; imem_req=0 while rst=0.
2. stall=1 for 3 cycles while at PC 16'h0010 with imem_valid=1 -> state BUF, imem_req=0, IF/ID and PC frozen; stall release -> buffered word appears in IF/ID with pc_plus2 16'h0012, next fetch at 16'h0012, no duplicate or lost word.
3. if_id_flush=1, br_target=16'h0040, hold=0 -> next cycle if_id_valid=0, if_id_instr=16'h0000, imem_addr=16'h0040. Repeat with control_stall=1 simultaneously -> flush ignored, PC unchanged.
4. Fetch of 16'hF000 at PC 16'h0020 -> if_id_instr=16'hF000, halted=1, imem_req=0, imem_addr stays 16'h0020. A later flush to 16'h0008 -> halted=0, fetch resumes at 16'h0008.
5. PC=16'hFFFE, word returned -> pc_plus2=16'h0000, next imem_addr=16'h0000.
6. imem_valid delayed 3 cycles, with rst pulled low during the wait -> all outputs return to reset values immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 16-bit core.
// Owns the PC, a one-entry fetch buffer for words returning under hold, and HLT detection.
module if_fetch_stage #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [15:0] NOP_INSTR  = 16'h0000,
   parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        control_stall,
   input  logic        if_id_flush,
   input  logic [15:0] br_target,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_valid,
   output logic [15:0] if_id_instr,
   output logic [15:0] if_id_pc_plus2,
   output logic        if_id_valid,
   output logic        halted
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_BUF   = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [15:0] pc_reg, pc_next;
   logic [15:0] buf_reg, buf_next;
   logic [15:0] instr_reg, instr_next;
   logic [15:0] pc_plus2_reg, pc_plus2_next;
   logic        valid_reg, valid_next;
   logic        halted_reg, halted_next;

   logic        hold;
   logic [15:0] pc_plus2;

   assign hold     = stall | control_stall;
   assign pc_plus2 = pc_reg + 16'd2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= ST_FETCH;
         pc_reg       <= RESET_PC;
         buf_reg      <= NOP_INSTR;
         instr_reg    <= NOP_INSTR;
         pc_plus2_reg <= 16'h0000;
         valid_reg    <= 1'b0;
         halted_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         buf_reg      <= buf_next;
         instr_reg    <= instr_next;
         pc_plus2_reg <= pc_plus2_next;
         valid_reg    <= valid_next;
         halted_reg   <= halted_next;
      end
   end

   // Hold has priority over flush: a flush seen under hold belongs to an unresolved branch.
   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      buf_next      = buf_reg;
      instr_next    = instr_reg;
      pc_plus2_next = pc_plus2_reg;
      valid_next    = valid_reg;
      halted_next   = halted_reg;
      case (state_reg)
         ST_FETCH: begin
            if (hold) begin
               if (imem_valid) begin
                  buf_next   = imem_rdata;
                  state_next = ST_BUF;
               end
            end else if (if_id_flush) begin
               instr_next    = NOP_INSTR;
               pc_plus2_next = 16'h0000;
               valid_next    = 1'b0;
               pc_next       = br_target;
            end else if (imem_valid) begin
               instr_next    = imem_rdata;
               pc_plus2_next = pc_plus2;
               valid_next    = 1'b1;
               if (imem_rdata[15:12] == HLT_OPCODE) begin
                  state_next  = ST_HALT;
                  halted_next = 1'b1;
               end else begin
                  pc_next = pc_plus2;
               end
            end else begin
               instr_next    = NOP_INSTR;
               pc_plus2_next = pc_plus2;
               valid_next    = 1'b0;
            end
         end
         ST_BUF: begin
            if (!hold) begin
               state_next = ST_FETCH;
               if (if_id_flush) begin
                  instr_next    = NOP_INSTR;
                  pc_plus2_next = pc_plus2;
                  valid_next    = 1'b0;
                  pc_next       = br_target;
               end else begin
                  instr_next    = buf_reg;
                  pc_plus2_next = pc_plus2;
                  valid_next    = 1'b1;
                  if (buf_reg[15:12] == HLT_OPCODE) begin
                     state_next  = ST_HALT;
                     halted_next = 1'b1;
                  end else begin
                     pc_next = pc_plus2;
                  end
               end
            end
         end
         ST_HALT: begin
            if (!hold) begin
               instr_next    = NOP_INSTR;
               pc_plus2_next = pc_plus2;
               valid_next    = 1'b0;
               // A flush here means the HLT itself was fetched down a mispredicted path.
               if (if_id_flush) begin
                  state_next  = ST_FETCH;
                  halted_next = 1'b0;
                  pc_next     = br_target;
               end
            end
         end
         default: begin
            state_next = ST_FETCH;
         end
      endcase
   end

   // Gating with rst keeps the request low for the whole reset assertion.
   assign imem_req       = (state_reg == ST_FETCH) & rst;
   assign imem_addr      = pc_reg;
   assign if_id_instr    = instr_reg;
   assign if_id_pc_plus2 = pc_plus2_reg;
   assign if_id_valid    = valid_reg;
   assign halted         = halted_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a behavioural instruction memory with adjustable latency,
// a scoreboard of expected IF/ID entries, and immediate-assertion checks on control outputs.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, control_stall, if_id_flush;
   logic [15:0] br_target;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_valid;
   logic [15:0] if_id_instr, if_id_pc_plus2;
   logic        if_id_valid, halted;

   if_fetch_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .control_stall(control_stall),
      .if_id_flush(if_id_flush), .br_target(br_target),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .if_id_instr(if_id_instr), .if_id_pc_plus2(if_id_pc_plus2),
      .if_id_valid(if_id_valid), .halted(halted)
   );

   always #5 clk = ~clk;

   // Memory model: word pattern {k,k,k+1,k+2} with k in 1..14, optional HLT at one address.
   int          mem_lat = 0;
   int          wait_cnt = 0;
   logic [15:0] last_addr = 16'h0000;
   logic        hlt_en = 1'b0;
   logic [15:0] hlt_addr = 16'h0000;

   function automatic logic [15:0] word_at(input logic [15:0] a);
      logic [15:0] n;
      logic [3:0]  k;
      n = a >> 1;
      k = 4'((n % 16'd14) + 16'd1);
      return {k, k, 4'(k + 4'd1), 4'(k + 4'd2)};
   endfunction

   always_comb begin
      imem_rdata = (hlt_en && imem_addr == hlt_addr) ? 16'hF000 : word_at(imem_addr);
      imem_valid = imem_req && (wait_cnt >= mem_lat);
   end

   always @(posedge clk) begin
      if (!imem_req || imem_valid || imem_addr != last_addr) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
      last_addr <= imem_addr;
   end

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pp2;
   } exp_t;
   exp_t sb[$];

   int passed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic push(input logic [15:0] addr);
      exp_t e;
      e.instr = (hlt_en && addr == hlt_addr) ? 16'hF000 : word_at(addr);
      e.pp2   = addr + 16'd2;
      sb.push_back(e);
   endtask

   // One clock; an IF/ID update with valid=1 must match the oldest scoreboard entry.
   task automatic tick();
      logic adv;
      exp_t e;
      adv = rst && !(stall || control_stall);
      @(posedge clk);
      #1;
      if (adv && if_id_valid) begin
         total++;
         assert (sb.size() > 0) passed++;
         else $error("FAIL sb_extra: observed instr %h with empty scoreboard", if_id_instr);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_instr", if_id_instr, e.instr);
            chk("sb_pc_plus2", if_id_pc_plus2, e.pp2);
            $display("txn instr=%h pc_plus2=%h", if_id_instr, if_id_pc_plus2);
         end
      end
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; control_stall = 1'b0;
      if_id_flush = 1'b0; br_target = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", {15'd0, imem_req}, 16'd0);
      chk("rst_valid", {15'd0, if_id_valid}, 16'd0);
      chk("rst_instr", if_id_instr, 16'h0000);
      chk("rst_halted", {15'd0, halted}, 16'd0);

      // Zero-wait streaming from reset.
      rst = 1'b1;
      #1;
      chk("t1_req", {15'd0, imem_req}, 16'd1);
      for (int a = 0; a < 16; a += 2) push(16'(a));
      repeat (8) tick();
      chk("t1_addr", imem_addr, 16'h0010);

      // Word returning under stall is buffered and delivered once.
      stall = 1'b1;
      repeat (3) begin
         tick();
         chk("t2_req", {15'd0, imem_req}, 16'd0);
         chk("t2_addr", imem_addr, 16'h0010);
         chk("t2_instr_hold", if_id_instr, word_at(16'h000E));
      end
      stall = 1'b0;
      push(16'h0010); push(16'h0012);
      tick();
      chk("t2_next_addr", imem_addr, 16'h0012);
      tick();

      // Flush redirect, then flush masked by control_stall.
      if_id_flush = 1'b1; br_target = 16'h0040;
      tick();
      chk("t3_valid", {15'd0, if_id_valid}, 16'd0);
      chk("t3_instr", if_id_instr, 16'h0000);
      chk("t3_addr", imem_addr, 16'h0040);
      control_stall = 1'b1; br_target = 16'h0080;
      tick();
      chk("t3_masked_addr", imem_addr, 16'h0040);
      if_id_flush = 1'b0; control_stall = 1'b0;
      push(16'h0040);
      tick();
      chk("t3_resume_addr", imem_addr, 16'h0042);

      // HLT halts fetch; a later flush undoes it.
      if_id_flush = 1'b1; br_target = 16'h0020;
      tick();
      if_id_flush = 1'b0; hlt_en = 1'b1; hlt_addr = 16'h0020;
      push(16'h0020);
      tick();
      chk("t4_halted", {15'd0, halted}, 16'd1);
      chk("t4_req", {15'd0, imem_req}, 16'd0);
      repeat (2) tick();
      chk("t4_addr", imem_addr, 16'h0020);
      chk("t4_bubble", {15'd0, if_id_valid}, 16'd0);
      if_id_flush = 1'b1; br_target = 16'h0008;
      tick();
      chk("t4_unhalt", {15'd0, halted}, 16'd0);
      chk("t4_redirect", imem_addr, 16'h0008);
      chk("t4_req_back", {15'd0, imem_req}, 16'd1);
      if_id_flush = 1'b0; hlt_en = 1'b0;
      push(16'h0008);
      tick();

      // PC wrap at the top of the address space.
      if_id_flush = 1'b1; br_target = 16'hFFFE;
      tick();
      if_id_flush = 1'b0;
      push(16'hFFFE);
      tick();
      chk("t5_wrap_addr", imem_addr, 16'h0000);

      // Reset during a slow fetch abandons it.
      if_id_flush = 1'b1; br_target = 16'h0030; mem_lat = 3;
      tick();
      if_id_flush = 1'b0;
      repeat (2) tick();
      chk("t6_waiting", {15'd0, if_id_valid}, 16'd0);
      rst = 1'b0;
      #1;
      chk("t6_rst_req", {15'd0, imem_req}, 16'd0);
      chk("t6_rst_addr", imem_addr, 16'h0000);
      chk("t6_rst_pp2", if_id_pc_plus2, 16'h0000);
      chk("t6_rst_halted", {15'd0, halted}, 16'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      push(16'h0000);
      for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
      chk("t6_restart_addr", imem_addr, 16'h0002);

      total++;
      assert (sb.size() == 0) passed++;
      else $error("FAIL sb_drain: observed %0d pending entries expected 0", sb.size());

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
